// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo: PS/2 device-to-host receiver with scancode FIFO and packed 32-bit status word.
module ps2_scan_fifo #(
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2clk,
  input  logic        ps2data,
  input  logic        rd,
  output logic        irq,
  output logic [31:0] out
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  state_t state;
  logic ck1, ck2, ckp, d1, d2, half;
  logic [3:0] bitcnt;
  logic [9:0] sh;
  logic [TW-1:0] tcnt;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rp, wp, rp_n, wp_n;
  logic [3:0] cnt, cnt_n;
  logic ovf, ferr, ovf_n, ferr_n;
  logic fall, valid, push, pop, acc;
  logic [7:0] head_n;
  // Next-state FIFO view so out can reflect the edge that pushes or pops.
  always_comb begin
    fall = ckp & ~ck2;
    valid = (^sh[8:0]) & sh[9];
    push = (state == CHECK) & valid;
    pop = rd & (cnt != 4'd0);
    acc = push & ((cnt != 4'(DEPTH)) | pop);
    rp_n = pop ? rp + AW'(1) : rp;
    wp_n = acc ? wp + AW'(1) : wp;
    cnt_n = cnt + 4'(acc) - 4'(pop);
    ovf_n = (ovf & ~rd) | (push & ~acc);
    ferr_n = (ferr & ~rd) | ((state == CHECK) & ~valid);
    head_n = (cnt_n == 4'd0) ? 8'h00 : (acc && wp == rp_n) ? sh[7:0] : mem[rp_n];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {ck1, ck2, ckp, d1, d2} <= 5'b11111;
      state <= IDLE;
      bitcnt <= 4'd0;
      sh <= 10'd0;
      tcnt <= '0;
      half <= 1'b0;
    end else begin
      {ck1, ck2, ckp} <= {ps2clk, ck1, ck2};
      {d1, d2} <= {ps2data, d1};
      case (state)
        IDLE: begin
          tcnt <= '0;
          half <= 1'b0;
          if (fall && !d2) begin
            state <= RECV;
            bitcnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            sh <= {d2, sh[9:1]};
            bitcnt <= bitcnt + 4'd1;
            tcnt <= '0;
            half <= 1'b0;
            if (bitcnt == 4'd10) state <= CHECK;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
            bitcnt <= 4'd0;
          end else begin
            half <= ~half;
            if (half) tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          bitcnt <= 4'd0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      cnt <= 4'd0;
      ovf <= 1'b0;
      ferr <= 1'b0;
      irq <= 1'b0;
      out <= 32'd0;
    end else begin
      rp <= rp_n;
      wp <= wp_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
      ferr <= ferr_n;
      irq <= acc;
      out <= {cnt_n != 4'd0, ovf_n, ferr_n, 9'd0, cnt_n, 8'd0, head_n};
    end
  end
  always_ff @(posedge clk)
    if (acc) mem[wp] <= sh[7:0];
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// tb_ps2_scan_fifo: scoreboard bench driving PS/2 frames and CPU pops against a reference FIFO model.
`timescale 1ns/1ps
module tb_ps2_scan_fifo;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 200;
  logic clk = 0, rst = 1, ps2clk = 1, ps2data = 1, rd = 0;
  logic irq;
  logic [31:0] out;
  int vec = 0, err = 0, irq_cnt = 0, irq0;
  logic [7:0] sb[$];
  bit ovf_m = 0, ferr_m = 0;

  ps2_scan_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data),
    .rd(rd), .irq(irq), .out(out)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (irq) irq_cnt++;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 10ms", $time);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word();
    logic [3:0] c;
    c = 4'(sb.size());
    return {c != 0, ovf_m, ferr_m, 9'd0, c, 8'd0, (c != 0) ? sb[0] : 8'h00};
  endfunction

  function automatic void model_push(input logic [7:0] b, input bit ok);
    if (!ok) ferr_m = 1;
    else if (sb.size() < DEPTH) sb.push_back(b);
    else ovf_m = 1;
  endfunction

  function automatic void model_pop();
    if (sb.size() > 0) void'(sb.pop_front());
    ovf_m = 0;
    ferr_m = 0;
  endfunction

  // rd_chk raises rd exactly in the cycle the receiver sits in CHECK.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nedges, input bit rd_chk);
    logic [10:0] bits;
    bits = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2data = bits[i];
      cyc(10);
      ps2clk = 0;
      if (i == 10 && rd_chk) begin
        cyc(3);
        rd = 1;
        cyc(1);
        rd = 0;
        cyc(16);
      end else cyc(20);
      ps2clk = 1;
      cyc(10);
    end
    ps2data = 1;
    cyc(10);
    if (nedges == 11 && rd_chk) model_pop();
    if (nedges == 11) model_push(b, !bad_par);
  endtask

  task automatic do_pop();
    rd = 1;
    cyc(1);
    rd = 0;
    model_pop();
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(3);
    vec++; if (out !== 32'd0) begin err++; $display("FAIL reset_out: got %h want 00000000", out); end
    vec++; if (irq !== 1'b0) begin err++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 0;
    cyc(2);
  endtask

  task automatic test_valid();
    irq0 = irq_cnt;
    send_frame(8'h1C, 0, 11, 0);
    vec++; if (irq_cnt - irq0 !== 1) begin err++; $display("FAIL valid_irq: got %0d want 1", irq_cnt - irq0); end
    vec++; if (out !== 32'h8001001C || exp_word() !== 32'h8001001C) begin err++; $display("FAIL valid_out: got %h want 8001001C", out); end
    do_pop();
    vec++; if (out !== 32'h0) begin err++; $display("FAIL valid_pop: got %h want 00000000", out); end
    do_pop();
    vec++; if (out !== exp_word()) begin err++; $display("FAIL empty_pop: got %h want %h", out, exp_word()); end
  endtask

  task automatic test_parity();
    irq0 = irq_cnt;
    send_frame(8'h1C, 1, 11, 0);
    vec++; if (irq_cnt !== irq0) begin err++; $display("FAIL parity_irq: got %0d want 0", irq_cnt - irq0); end
    vec++; if (out !== 32'h20000000) begin err++; $display("FAIL parity_out: got %h want 20000000", out); end
    do_pop();
    vec++; if (out !== 32'h0) begin err++; $display("FAIL parity_clear: got %h want 00000000", out); end
  endtask

  task automatic test_overflow();
    irq0 = irq_cnt;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 11, 0);
    vec++; if (irq_cnt - irq0 !== 8) begin err++; $display("FAIL ovf_irq: got %0d want 8", irq_cnt - irq0); end
    vec++; if (out !== 32'hC0080001) begin err++; $display("FAIL ovf_out: got %h want C0080001", out); end
    for (int i = 0; i < 8; i++) begin
      do_pop();
      vec++; if (out !== exp_word()) begin err++; $display("FAIL ovf_pop%0d: got %h want %h", i, out, exp_word()); end
    end
  endtask

  task automatic test_timeout();
    irq0 = irq_cnt;
    send_frame(8'h33, 0, 5, 0);
    cyc(2 * TIMEOUT + 20);
    send_frame(8'hF0, 0, 11, 0);
    vec++; if (irq_cnt - irq0 !== 1) begin err++; $display("FAIL timeout_irq: got %0d want 1", irq_cnt - irq0); end
    vec++; if (out !== 32'h800100F0) begin err++; $display("FAIL timeout_out: got %h want 800100F0", out); end
    do_pop();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 0, 11, 0);
    irq0 = irq_cnt;
    send_frame(8'hAA, 0, 11, 1);
    vec++; if (irq_cnt - irq0 !== 1) begin err++; $display("FAIL b2b_irq: got %0d want 1", irq_cnt - irq0); end
    vec++; if (out !== 32'h80080011 || out !== exp_word()) begin err++; $display("FAIL b2b_out: got %h want 80080011", out); end
    for (int i = 0; i < 7; i++) begin
      do_pop();
      vec++; if (out !== exp_word()) begin err++; $display("FAIL b2b_pop%0d: got %h want %h", i, out, exp_word()); end
    end
    vec++; if (out[7:0] !== 8'hAA) begin err++; $display("FAIL b2b_head: got %h want AA", out[7:0]); end
    do_pop();
  endtask

  task automatic test_rst_mid();
    send_frame(8'h42, 0, 11, 0);
    send_frame(8'h77, 0, 6, 0);
    @(posedge clk);
    #3 rst = 1;
    #2;
    sb.delete();
    ovf_m = 0;
    ferr_m = 0;
    vec++; if (out !== 32'd0 || irq !== 1'b0) begin err++; $display("FAIL midrst: got out=%h irq=%b want 00000000/0", out, irq); end
    rst = 0;
    cyc(5);
    irq0 = irq_cnt;
    send_frame(8'h5A, 0, 11, 0);
    vec++; if (irq_cnt - irq0 !== 1) begin err++; $display("FAIL midrst_irq: got %0d want 1", irq_cnt - irq0); end
    vec++; if (out !== 32'h8001005A) begin err++; $display("FAIL midrst_out: got %h want 8001005A", out); end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_parity();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
